misr_ora_cmp: RTL and testbench



---
 rtl/bist_pkg.sv | 27 ++
 rtl/misr_core.sv | 39 +++
 rtl/misr_ora_cmp.sv | 100 ++++++++++
 tb/tb_misr_ora_cmp.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST output response analyser.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Default feedback taps per supported MISR width (bit i set: top bit feeds stage i).
  localparam logic [3:0]  POLY_W4  = 4'b1000;
  localparam logic [7:0]  POLY_W8  = 8'b1011_1000;
  localparam logic [15:0] POLY_W16 = 16'hB400;
  localparam logic [31:0] POLY_W32 = 32'h8020_0003;

  // Picks the default tap set for a given width; unsupported widths fall back to a plain shift.
  function automatic logic [31:0] default_poly(input int width);
    case (width)
      4:       return {28'd0, POLY_W4};
      8:       return {24'd0, POLY_W8};
      16:      return {16'd0, POLY_W16};
      32:      return POLY_W32;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/misr_core.sv
// Parametrised multiple-input signature register with seed load and enable.
module misr_core
  import bist_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] misr
);

  logic [WIDTH-1:0] misr_next;

  // Next state: shift up, fold the top bit back through the taps, XOR in the response word.
  always_comb begin
    misr_next    = '0;
    misr_next[0] = misr[WIDTH-1] ^ data[0];
    for (int i = 1; i < WIDTH; i++) begin
      misr_next[i] = misr[i-1] ^ (POLY[i] & misr[WIDTH-1]) ^ data[i];
    end
  end

  // Signature register: seed on reset or load, compact only when enabled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      misr <= SEED;
    end else if (load) begin
      misr <= SEED;
    end else if (en) begin
      misr <= misr_next;
    end
  end

endmodule

// File: rtl/misr_ora_cmp.sv
// BIST output response analyser: compacts a window of CUT responses and
// compares the signature against a golden value with a start/done handshake.
module misr_ora_cmp
  import bist_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic [WIDTH-1:0] golden,
  input  logic [WIDTH-1:0] resp_in,
  input  logic             resp_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] win_len_q;
  logic [WIDTH-1:0] golden_q;
  logic [WIDTH-1:0] misr;
  logic             load;
  logic             accept;

  assign load      = (state == IDLE) && start;
  assign accept    = (state == RUN) && resp_valid;
  assign count_inc = count + CNT_W'(1);
  assign signature = misr;

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .en      (accept),
    .data    (resp_in),
    .misr    (misr)
  );

  // Window parameters are captured once per accepted start; they need no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      win_len_q <= win_len;
      golden_q  <= golden;
    end
  end

  // Window control: IDLE waits for start, RUN counts accepted responses, CHECK compares once.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            pass  <= 1'b0;
            busy  <= 1'b1;
            state <= (win_len == '0) ? CHECK : RUN;
          end
        end
        RUN: begin
          if (resp_valid) begin
            count <= count_inc;
            if (count_inc == win_len_q) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          pass  <= (misr == golden_q);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_misr_ora_cmp.sv
// Directed bench for misr_ora_cmp: a 4-bit legacy instance and an 8-bit instance
// share one clock and reset; window results flow through a scoreboard queue.
module tb_misr_ora_cmp;

  localparam logic [7:0] SEED8 = 8'hA5;
  localparam logic [7:0] POLY8 = 8'b1011_1000;

  logic        clk;
  logic        reset_n;

  logic        start4, rv4, busy4, done4, pass4;
  logic [15:0] win_len4;
  logic [3:0]  golden4, resp4, sig4;

  logic        start8, rv8, busy8, done8, pass8;
  logic [15:0] win_len8;
  logic [7:0]  golden8, resp8, sig8;

  typedef struct {
    logic        p;
    logic [31:0] s;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  misr_ora_cmp #(.WIDTH(4), .POLY(4'b1000), .SEED(4'b0000), .CNT_W(16)) dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start4),
    .win_len    (win_len4),
    .golden     (golden4),
    .resp_in    (resp4),
    .resp_valid (rv4),
    .busy       (busy4),
    .done       (done4),
    .pass       (pass4),
    .signature  (sig4)
  );

  misr_ora_cmp #(.WIDTH(8), .POLY(POLY8), .SEED(SEED8), .CNT_W(16)) dut8 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start8),
    .win_len    (win_len8),
    .golden     (golden8),
    .resp_in    (resp8),
    .resp_valid (rv8),
    .busy       (busy8),
    .done       (done8),
    .pass       (pass8),
    .signature  (sig8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference MISR step: shift, fold the top bit through (taps | stage 0), add response.
  function automatic logic [31:0] mstep(input logic [31:0] m, input logic [31:0] r,
                                        input logic [31:0] poly, input int w);
    logic [31:0] mask;
    logic [31:0] n;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    n = (m << 1) & mask;
    if (m[w-1]) n = n ^ ((poly | 32'd1) & mask);
    return (n ^ r) & mask;
  endfunction

  task automatic wait_done(input bit is8, input int budget, output int cycles);
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      cycles++;
      if ((is8 ? done8 : done4) === 1'b1) return;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_result(input bit is8);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(is8 ? "pass8" : "pass4", {31'd0, is8 ? pass8 : pass4}, {31'd0, e.p});
      chk(is8 ? "sig8" : "sig4", is8 ? {24'd0, sig8} : {28'd0, sig4}, e.s);
      chk(is8 ? "busy8_at_done" : "busy4_at_done", {31'd0, is8 ? busy8 : busy4}, 32'd0);
    end
  endtask

  // Runs the legacy 1,0,0,0,0 window on the 4-bit instance against a given golden.
  task automatic legacy_window(input logic [3:0] g, input string tag);
    logic [31:0] m;
    int          cyc;
    logic [3:0]  seq [5];
    seq = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    start4 = 1'b1; win_len4 = 16'd5; golden4 = g;
    tick();
    start4 = 1'b0;
    chk({tag, "_busy_run"}, {31'd0, busy4}, 32'd1);
    chk({tag, "_pass_cleared"}, {31'd0, pass4}, 32'd0);
    m = 32'd0;
    for (int k = 0; k < 5; k++) begin
      m = mstep(m, {28'd0, seq[k]}, 32'h8, 4);
      if (k == 4) sb.push_back('{p: (m[3:0] == g), s: m});
      rv4 = 1'b1; resp4 = seq[k];
      tick();
      chk({tag, "_sig_step"}, {28'd0, sig4}, m);
    end
    rv4 = 1'b0; resp4 = 4'h0;
    chk({tag, "_no_early_done"}, {31'd0, done4}, 32'd0);
    wait_done(1'b0, 20, cyc);
    chk({tag, "_latency"}, cyc, 32'd1);
    check_result(1'b0);
  endtask

  // 100-word window on the 8-bit instance with random valid gaps.
  task automatic run8(input logic [7:0] rs [100], input logic [7:0] g, input logic [31:0] expsig);
    logic [31:0] m;
    int          cyc;
    sb.push_back('{p: (expsig[7:0] == g), s: expsig});
    start8 = 1'b1; win_len8 = 16'd100; golden8 = g;
    tick();
    start8 = 1'b0;
    m = {24'd0, SEED8};
    for (int k = 0; k < 100; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        rv8 = 1'b0; resp8 = 8'($urandom);
        tick();
      end
      rv8 = 1'b1; resp8 = rs[k];
      tick();
      m = mstep(m, {24'd0, rs[k]}, {24'd0, POLY8}, 8);
      chk("sig8_step", {24'd0, sig8}, m);
    end
    rv8 = 1'b0;
    wait_done(1'b1, 20, cyc);
    chk("lat8", cyc, 32'd1);
    check_result(1'b1);
  endtask

  initial begin
    logic [31:0] m;
    logic [31:0] exp5;
    logic [31:0] exp8;
    int          cyc;
    logic [7:0]  rs [100];

    reset_n = 1'b0;
    start4 = 1'b0; win_len4 = '0; golden4 = '0; resp4 = '0; rv4 = 1'b0;
    start8 = 1'b0; win_len8 = '0; golden8 = '0; resp8 = '0; rv8 = 1'b0;
    tick();
    tick();
    chk("rst_busy4", {31'd0, busy4}, 32'd0);
    chk("rst_done4", {31'd0, done4}, 32'd0);
    chk("rst_pass4", {31'd0, pass4}, 32'd0);
    chk("rst_sig4", {28'd0, sig4}, 32'd0);
    chk("rst_sig8", {24'd0, sig8}, {24'd0, SEED8});
    reset_n = 1'b1;
    tick();

    // Legacy match then a single-cycle done pulse with pass held.
    legacy_window(4'b1001, "legacy");
    tick();
    chk("done_pulse_low", {31'd0, done4}, 32'd0);
    chk("pass_held", {31'd0, pass4}, 32'd1);
    chk("sig_held", {28'd0, sig4}, 32'h9);

    // Same stimulus, wrong golden.
    legacy_window(4'b1000, "faildet");

    // Valid gaps: MISR holds while resp_valid is low.
    start4 = 1'b1; win_len4 = 16'd2; golden4 = 4'b1000;
    sb.push_back('{p: 1'b1, s: 32'h8});
    tick();
    start4 = 1'b0;
    rv4 = 1'b1; resp4 = 4'hF;
    tick();
    chk("gap_sig1", {28'd0, sig4}, 32'hF);
    rv4 = 1'b0; resp4 = 4'h6;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("gap_hold", {28'd0, sig4}, 32'hF);
      chk("gap_no_done", {31'd0, done4}, 32'd0);
    end
    rv4 = 1'b1; resp4 = 4'hF;
    tick();
    rv4 = 1'b0;
    chk("gap_sig2", {28'd0, sig4}, 32'h8);
    wait_done(1'b0, 20, cyc);
    chk("gap_latency", cyc, 32'd1);
    check_result(1'b0);

    // Zero-length window: straight to CHECK, done two edges after start.
    start4 = 1'b1; win_len4 = 16'd0; golden4 = 4'b0000;
    sb.push_back('{p: 1'b1, s: 32'h0});
    tick();
    start4 = 1'b0;
    chk("zero_busy", {31'd0, busy4}, 32'd1);
    chk("zero_no_done", {31'd0, done4}, 32'd0);
    wait_done(1'b0, 20, cyc);
    chk("zero_latency", cyc, 32'd1);
    check_result(1'b0);

    // start during RUN is ignored; start coincident with done opens a new window.
    m = mstep(32'd0, 32'h3, 32'h8, 4);
    m = mstep(m, 32'h5, 32'h8, 4);
    exp5 = mstep(m, 32'hC, 32'h8, 4);
    start4 = 1'b1; win_len4 = 16'd3; golden4 = exp5[3:0];
    sb.push_back('{p: 1'b1, s: exp5});
    tick();
    start4 = 1'b0;
    rv4 = 1'b1; resp4 = 4'h3;
    tick();
    start4 = 1'b1; win_len4 = 16'd1; golden4 = 4'h0; resp4 = 4'h5;
    tick();
    start4 = 1'b0;
    chk("busy_start_sig", {28'd0, sig4}, m);
    chk("busy_start_busy", {31'd0, busy4}, 32'd1);
    chk("busy_start_no_done", {31'd0, done4}, 32'd0);
    resp4 = 4'hC;
    tick();
    rv4 = 1'b0;
    wait_done(1'b0, 20, cyc);
    start4 = 1'b1; win_len4 = 16'd1; golden4 = 4'h6;
    check_result(1'b0);
    sb.push_back('{p: 1'b1, s: 32'h6});
    tick();
    start4 = 1'b0;
    chk("coinc_pass_cleared", {31'd0, pass4}, 32'd0);
    chk("coinc_busy", {31'd0, busy4}, 32'd1);
    chk("coinc_sig_seed", {28'd0, sig4}, 32'h0);
    rv4 = 1'b1; resp4 = 4'h6;
    tick();
    rv4 = 1'b0;
    wait_done(1'b0, 20, cyc);
    check_result(1'b0);

    // Reset in the middle of a window abandons it without a done pulse.
    start4 = 1'b1; win_len4 = 16'd4; golden4 = 4'h0;
    tick();
    start4 = 1'b0;
    rv4 = 1'b1; resp4 = 4'hA;
    tick();
    rv4 = 1'b0;
    reset_n = 1'b0;
    tick();
    chk("midrst_busy", {31'd0, busy4}, 32'd0);
    chk("midrst_sig", {28'd0, sig4}, 32'h0);
    chk("midrst_done", {31'd0, done4}, 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("midrst_no_done", {31'd0, done4}, 32'd0);
    end

    // 8-bit instance, random 100-word window: matching golden, then off by one bit.
    exp8 = {24'd0, SEED8};
    for (int k = 0; k < 100; k++) begin
      rs[k] = 8'($urandom);
      exp8  = mstep(exp8, {24'd0, rs[k]}, {24'd0, POLY8}, 8);
    end
    run8(rs, exp8[7:0], exp8);
    tick();
    run8(rs, exp8[7:0] ^ 8'h01, exp8);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
